// File: rtl/controle_exibicao_base_if.sv
// Bus between the ALU / converter path and the display control stage.
//
// Handshake: carregar is a one-cycle valid strobe qualifying resultado;
// there is no ready, the stage accepts a load on every edge where carregar
// is high. atualizado is a one-cycle valid pulse telling the consumer that
// valor_binario and/or base_selecionada were just refreshed.
interface controle_exibicao_base_if;
  logic       carregar;
  logic [7:0] resultado;
  logic [7:0] valor_binario;
  logic [1:0] base_selecionada;
  logic       atualizado;
  logic [1:0] estado_dbg;

  modport master (
    output carregar,
    output resultado,
    input  valor_binario,
    input  base_selecionada,
    input  atualizado,
    input  estado_dbg
  );

  modport slave (
    input  carregar,
    input  resultado,
    output valor_binario,
    output base_selecionada,
    output atualizado,
    output estado_dbg
  );
endinterface

// File: rtl/controle_exibicao_base.sv
// Display control stage: holds the ALU result for the base converter and
// steps the display base (dec -> hex -> oct) on each debounced button press.
// Both outputs only move on a load or on a qualified press, so the
// downstream converter always sees a steady operand.
module controle_exibicao_base #(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int LARGURA_CONT    = 19
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      botao_base_n,
  controle_exibicao_base_if.slave   bus
);

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONF_PRESS  = 2'd1,
    PRESSIONADO = 2'd2,
    CONF_SOLTA  = 2'd3
  } estado_t;

  localparam logic [LARGURA_CONT-1:0] CONT_FIM = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);
  localparam logic [LARGURA_CONT-1:0] CONT_UM  = LARGURA_CONT'(1);

  logic                    sync1;
  logic                    btn_s;
  estado_t                 estado;
  estado_t                 estado_nxt;
  logic [LARGURA_CONT-1:0] cont;
  logic [LARGURA_CONT-1:0] cont_nxt;
  logic                    passo;
  logic [1:0]              base_q;
  logic [1:0]              base_prox;
  logic [7:0]              valor_q;
  logic                    atualizado_q;

  // Two-flop synchronizer; resets to the released level (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      sync1 <= botao_base_n;
      btn_s <= sync1;
    end
  end

  // Debounce state and qualification counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= SOLTO;
      cont   <= '0;
    end else begin
      estado <= estado_nxt;
      cont   <= cont_nxt;
    end
  end

  // Debounce next state: a level is accepted after DEBOUNCE_CICLOS stable
  // cycles; the counter restarts on every state change.
  always_comb begin
    estado_nxt = estado;
    cont_nxt   = cont;
    passo      = 1'b0;
    case (estado)
      SOLTO: begin
        cont_nxt = '0;
        if (!btn_s) estado_nxt = CONF_PRESS;
      end
      CONF_PRESS: begin
        if (btn_s) begin
          estado_nxt = SOLTO;
          cont_nxt   = '0;
        end else if (cont == CONT_FIM) begin
          estado_nxt = PRESSIONADO;
          cont_nxt   = '0;
          passo      = 1'b1;
        end else begin
          cont_nxt = cont + CONT_UM;
        end
      end
      PRESSIONADO: begin
        cont_nxt = '0;
        if (btn_s) estado_nxt = CONF_SOLTA;
      end
      CONF_SOLTA: begin
        if (!btn_s) begin
          estado_nxt = PRESSIONADO;
          cont_nxt   = '0;
        end else if (cont == CONT_FIM) begin
          estado_nxt = SOLTO;
          cont_nxt   = '0;
        end else begin
          cont_nxt = cont + CONT_UM;
        end
      end
      default: begin
        estado_nxt = SOLTO;
        cont_nxt   = '0;
      end
    endcase
  end

  // Base sequence dec -> hex -> oct -> dec; an illegal 11 recovers to dec.
  always_comb begin
    base_prox = 2'b00;
    case (base_q)
      2'b00:   base_prox = 2'b01;
      2'b01:   base_prox = 2'b10;
      default: base_prox = 2'b00;
    endcase
  end

  // Output registers: result load, base step and a single merged update pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor_q      <= 8'h00;
      base_q       <= 2'b00;
      atualizado_q <= 1'b0;
    end else begin
      if (bus.carregar) valor_q <= bus.resultado;
      if (passo)        base_q  <= base_prox;
      atualizado_q <= bus.carregar | passo;
    end
  end

  assign bus.valor_binario    = valor_q;
  assign bus.base_selecionada = base_q;
  assign bus.atualizado       = atualizado_q;
  assign bus.estado_dbg       = estado;

endmodule

// File: tb/tb_controle_exibicao_base.sv
// Bench for controle_exibicao_base with a short debounce window.
module tb_controle_exibicao_base;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic botao_base_n = 1'b1;

  controle_exibicao_base_if bus ();

  controle_exibicao_base #(
    .DEBOUNCE_CICLOS(D),
    .LARGURA_CONT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .botao_base_n(botao_base_n),
    .bus(bus)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the button is accepted after D+1 consecutive samples
  // (as seen two edges late) at the opposite level; a press acceptance steps
  // the base. Each update pushes the expected output pair to the queue.
  logic [7:0] m_val;
  logic [1:0] m_base;
  logic       m_upd;
  logic       m_pressed;
  int         m_run;
  logic       dly[$];

  always @(posedge clk or negedge rst_n) begin : model
    logic seen;
    logic step;
    logic target;
    if (!rst_n) begin
      m_val = 8'h00; m_base = 2'b00; m_upd = 1'b0;
      m_pressed = 1'b0; m_run = 0;
      dly = '{1'b1, 1'b1};
      exp_q.delete();
    end else begin
      seen = dly.pop_front();
      dly.push_back(botao_base_n);
      step = 1'b0;
      target = m_pressed ? 1'b1 : 1'b0;
      if (seen == target) m_run++;
      else m_run = 0;
      if (m_run == D + 1) begin
        m_pressed = ~m_pressed;
        m_run = 0;
        step = m_pressed;
      end
      if (step) m_base = (m_base == 2'd2) ? 2'd0 : m_base + 2'd1;
      if (bus.carregar) m_val = bus.resultado;
      m_upd = bus.carregar | step;
      if (m_upd) exp_q.push_back({m_val, m_base});
    end
  end

  // Monitor: continuous output check plus scoreboard pop on every update pulse.
  always @(negedge clk) begin : monitor
    logic [9:0] e;
    if (rst_n) begin
      check("valor", bus.valor_binario, m_val);
      check("base", bus.base_selecionada, m_base);
      check("atualizado", bus.atualizado, m_upd);
      if (bus.atualizado) begin
        pulse_cnt++;
        check("pulse_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pulse_valor", bus.valor_binario, e[9:2]);
          check("pulse_base", bus.base_selecionada, e[1:0]);
        end
      end
    end
  end

  // Driver tasks (entered and left at a negedge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    bus.carregar = 1'b1;
    bus.resultado = v;
    @(negedge clk);
    bus.carregar = 1'b0;
  endtask

  // Counts edges from the first edge that can sample the button until the
  // base register changes.
  task automatic wait_step(output int lat);
    logic [1:0] b0;
    b0 = bus.base_selecionada;
    @(posedge clk);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.base_selecionada != b0) break;
    end
    @(negedge clk);
  endtask

  task automatic press_release(input logic [1:0] exp_base);
    botao_base_n = 1'b0;
    tick(10);
    check("press_base", bus.base_selecionada, exp_base);
    botao_base_n = 1'b1;
    tick(10);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    int p0;
    int hold;
    bus.carregar = 1'b0;
    bus.resultado = 8'h00;

    // 1. reset and idle
    tick(3);
    check("rst_valor", bus.valor_binario, 8'h00);
    check("rst_base", bus.base_selecionada, 2'b00);
    check("rst_atualizado", bus.atualizado, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_valor", bus.valor_binario, 8'h00);
      check("idle_atualizado", bus.atualizado, 1'b0);
    end

    // 2. single load, then resultado change without strobe
    load(8'hA7);
    check("load_valor", bus.valor_binario, 8'hA7);
    check("load_pulse", bus.atualizado, 1'b1);
    bus.resultado = 8'h3C;
    tick(1);
    check("load_pulse_end", bus.atualizado, 1'b0);
    tick(3);
    check("hold_valor", bus.valor_binario, 8'hA7);

    // back-to-back loads
    bus.carregar = 1'b1; bus.resultado = 8'h11;
    tick(1);
    check("b2b_1", bus.atualizado, 1'b1);
    bus.resultado = 8'h11;
    tick(1);
    bus.carregar = 1'b0;
    check("b2b_2", bus.atualizado, 1'b1);
    check("b2b_valor", bus.valor_binario, 8'h11);
    tick(2);

    // 3. long press: one step, fixed latency
    p0 = pulse_cnt;
    botao_base_n = 1'b0;
    wait_step(lat);
    check("press_latency", lat, 2 + D);
    tick(14);
    check("held_base", bus.base_selecionada, 2'b01);
    check("held_single_step", pulse_cnt - p0, 1);
    botao_base_n = 1'b1;
    tick(10);
    press_release(2'b10);
    press_release(2'b00);
    press_release(2'b01);

    // 4. bounce never qualifies
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      botao_base_n = 1'b0; tick(3);
      botao_base_n = 1'b1; tick(1);
    end
    tick(10);
    check("bounce_base", bus.base_selecionada, 2'b01);
    check("bounce_pulses", pulse_cnt - p0, 0);

    // 5. press qualifies on the same edge as a load
    p0 = pulse_cnt;
    botao_base_n = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    load(8'hFF);
    check("simul_base", bus.base_selecionada, 2'b10);
    check("simul_valor", bus.valor_binario, 8'hFF);
    tick(4);
    check("simul_single_pulse", pulse_cnt - p0, 1);
    botao_base_n = 1'b1;
    tick(10);

    // 6. reset during press qualification
    load(8'h55);
    tick(1);
    botao_base_n = 1'b0;
    tick(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valor", bus.valor_binario, 8'h00);
    check("midrst_base", bus.base_selecionada, 2'b00);
    check("midrst_atualizado", bus.atualizado, 1'b0);
    check("midrst_estado", bus.estado_dbg, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_step(lat);
    check("requal_latency", lat, 2 + D);
    check("requal_base", bus.base_selecionada, 2'b01);
    botao_base_n = 1'b1;
    tick(10);

    // random phase
    hold = 0;
    for (int i = 0; i < 2000; i++) begin
      bus.carregar = ($urandom_range(0, 3) == 0);
      bus.resultado = 8'($urandom());
      if (hold == 0) begin
        botao_base_n = $urandom_range(0, 1);
        hold = $urandom_range(1, 10);
      end
      hold--;
      tick(1);
    end
    bus.carregar = 1'b0;
    botao_base_n = 1'b1;
    tick(20);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
